// File: rtl/fire_ctrl_pkg.sv
// Shared types and default constants for the fire controller.
// The optional one-deep shot queue is enabled by defining FIRE_QUEUE_EN.
package fire_ctrl_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_COOLDOWN_TICKS  = 8;

    // Cooldown counter is sized for the full 0..255 tick range.
    localparam int COOLDOWN_W = 8;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer.
// rise pulses for one cycle on the same edge the accepted level goes high.
module button_debounce
    import fire_ctrl_pkg::*;
#(
    parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int              CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    // The count only runs while the synchronized input disagrees with the
    // accepted level; a single agreeing cycle starts the wait over.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                db_q   <= sync2_q;
                rise_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign dout = db_q;
    assign rise = rise_q;

endmodule

// File: rtl/fire_ctrl.sv
// Trigger-to-shot controller: debounced press, fire held until a game tick,
// then a tick-counted cooldown. Define FIRE_QUEUE_EN for a one-deep press queue.
module fire_ctrl
    import fire_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int COOLDOWN_TICKS  = DEFAULT_COOLDOWN_TICKS,
    parameter int SHOT_W          = 8
) (
    input  logic              board_clk,
    input  logic              reset,
    input  logic              game_tick,
    input  logic              btn_raw,
    input  logic              bullet_onscreen,
    input  logic              game_active,
    output logic              fire,
    output logic              ready,
    output logic [SHOT_W-1:0] shots_fired
);

    localparam logic [COOLDOWN_W-1:0] COOL_LOAD = COOLDOWN_W'(COOLDOWN_TICKS);
    localparam logic [SHOT_W-1:0]     SHOT_MAX  = '1;

    logic              btnLevel;
    logic              btnRise;
    logic              press;
    logic              pendActive;
    logic              launch;

    fire_state_e       state_q;
    logic              fire_q;
    logic [COOLDOWN_W-1:0] cool_q;
    logic [SHOT_W-1:0] shots_q;
    logic [SHOT_W-1:0] shots_d;

    button_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (board_clk),
        .reset (reset),
        .din   (btn_raw),
        .dout  (btnLevel),
        .rise  (btnRise)
    );

    // A rise is only meaningful while the accepted level is actually high.
    assign press = btnRise && btnLevel;

    assign ready   = (state_q == ARMED) && game_active && !bullet_onscreen;
    assign launch  = ready && (press || pendActive);
    assign shots_d = (shots_q == SHOT_MAX) ? shots_q : shots_q + SHOT_W'(1);

    // Losing game_active snaps everything back to ARMED but keeps the score.
    always_ff @(posedge board_clk) begin
        if (reset) begin
            state_q <= ARMED;
            fire_q  <= 1'b0;
            cool_q  <= '0;
            shots_q <= '0;
        end else if (!game_active) begin
            state_q <= ARMED;
            fire_q  <= 1'b0;
            cool_q  <= '0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (launch) begin
                        state_q <= FIRE;
                        fire_q  <= 1'b1;
                        shots_q <= shots_d;
                    end
                end
                FIRE: begin
                    if (game_tick) begin
                        fire_q <= 1'b0;
                        if (COOLDOWN_TICKS == 0) begin
                            state_q <= ARMED;
                        end else begin
                            state_q <= COOLDOWN;
                            cool_q  <= COOL_LOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    if (game_tick) begin
                        if (cool_q <= COOLDOWN_W'(1)) begin
                            state_q <= ARMED;
                            cool_q  <= '0;
                        end else begin
                            cool_q <= cool_q - COOLDOWN_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ARMED;
                    fire_q  <= 1'b0;
                    cool_q  <= '0;
                end
            endcase
        end
    end

`ifdef FIRE_QUEUE_EN
    logic pend_q;

    // One remembered press; extra presses while it waits are simply absorbed.
    always_ff @(posedge board_clk) begin
        if (reset || !game_active) begin
            pend_q <= 1'b0;
        end else if (launch) begin
            pend_q <= 1'b0;
        end else if (press) begin
            pend_q <= 1'b1;
        end
    end

    assign pendActive = pend_q;
`else
    assign pendActive = 1'b0;
`endif

    assign fire        = fire_q;
    assign shots_fired = shots_q;

endmodule

// File: tb/tb_fire_ctrl.sv
// Directed scoreboard bench for fire_ctrl (debounce 4, cooldown 2, tick every 16).
// A second instance with zero cooldown exercises shot-counter saturation.
`timescale 1ns/1ps
module tb_fire_ctrl;

    logic       board_clk = 1'b0;
    logic       reset;
    logic       game_tick;
    logic       btn_raw;
    logic       bullet_onscreen;
    logic       game_active;
    logic       fire;
    logic       ready;
    logic [7:0] shots_fired;

    logic       btn0;
    logic       bos0;
    logic       fire0;
    logic       ready0;
    logic [7:0] shots0;

    int nAsserts;
    int nFails;
    int holdLeft;
    int holdLeft0;
    int shotsModel;
    int shots0Model;
    int expShots[$];
    int n;
    logic sawFire;

    always #5 board_clk = ~board_clk;

    fire_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .COOLDOWN_TICKS  (2),
        .SHOT_W          (8)
    ) dut (
        .board_clk       (board_clk),
        .reset           (reset),
        .game_tick       (game_tick),
        .btn_raw         (btn_raw),
        .bullet_onscreen (bullet_onscreen),
        .game_active     (game_active),
        .fire            (fire),
        .ready           (ready),
        .shots_fired     (shots_fired)
    );

    fire_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .COOLDOWN_TICKS  (0),
        .SHOT_W          (8)
    ) dut0 (
        .board_clk       (board_clk),
        .reset           (reset),
        .game_tick       (game_tick),
        .btn_raw         (btn0),
        .bullet_onscreen (bos0),
        .game_active     (game_active),
        .fire            (fire0),
        .ready           (ready0),
        .shots_fired     (shots0)
    );

    // Game tick: one-cycle pulse every 16 clocks, changed just after a rising edge.
    initial begin
        game_tick = 1'b0;
        forever begin
            repeat (15) @(posedge board_clk);
            #2 game_tick = 1'b1;
            @(posedge board_clk);
            #2 game_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge and release any timed button holds.
    task automatic step();
        @(negedge board_clk);
        if (holdLeft > 0) begin
            holdLeft--;
            if (holdLeft == 0) btn_raw = 1'b0;
        end
        if (holdLeft0 > 0) begin
            holdLeft0--;
            if (holdLeft0 == 0) btn0 = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int hold);
        btn_raw  = 1'b1;
        holdLeft = hold;
    endtask

    task automatic scoreShots(input string tag, input logic [31:0] observed);
        int e;
        e = -1;
        if (expShots.size() > 0) e = expShots.pop_front();
        checkOutput(tag, observed, e);
    endtask

    task automatic waitTickEnd();
        int k;
        k = 0;
        while (game_tick !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        checkOutput("tick_timeout", k >= 40, 0);
        step();
    endtask

    task automatic waitFireRise(input string tag, output int cyc);
        cyc = 0;
        while (fire !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        checkOutput({tag, "_rise_timeout"}, cyc >= 60, 0);
    endtask

    task automatic waitFireFall(input string tag);
        int   k;
        logic done;
        k    = 0;
        done = 1'b0;
        while (!done && k < 60) begin
            if (game_tick === 1'b1) begin
                checkOutput({tag, "_fire_at_tick"}, fire, 1);
                step();
                checkOutput({tag, "_fire_after_tick"}, fire, 0);
                done = 1'b1;
            end else begin
                step();
                k++;
            end
        end
        checkOutput({tag, "_fall_timeout"}, done, 1);
    endtask

    task automatic waitReadyHigh(input string tag, input int bound);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < bound) begin
            step();
            k++;
        end
        checkOutput({tag, "_timeout"}, k >= bound, 0);
    endtask

    task automatic watchNoFire(input int cycles);
        sawFire = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (fire !== 1'b0) sawFire = 1'b1;
        end
    endtask

    initial begin
        nAsserts    = 0;
        nFails      = 0;
        holdLeft    = 0;
        holdLeft0   = 0;
        shotsModel  = 0;
        shots0Model = 0;
        reset           = 1'b1;
        btn_raw         = 1'b0;
        btn0            = 1'b0;
        bos0            = 1'b0;
        bullet_onscreen = 1'b0;
        game_active     = 1'b1;

        repeat (3) step();
        checkOutput("reset_fire", fire, 0);
        checkOutput("reset_shots", shots_fired, 0);
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_shots0", shots0, 0);
        reset = 1'b0;
        step();

        // Bouncing trigger never holds long enough to be accepted.
        sawFire = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn_raw = ~btn_raw;
            step();
            if (fire !== 1'b0) sawFire = 1'b1;
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fire !== 1'b0) sawFire = 1'b1;
        end
        checkOutput("bounce_saw_fire", sawFire, 0);
        checkOutput("bounce_fire", fire, 0);
        checkOutput("bounce_shots", shots_fired, 0);

        // Clean press: sync(2) + debounce(4) + FSM(1) = fire on the 7th cycle.
        waitTickEnd();
        shotsModel++;
        expShots.push_back(shotsModel);
        applyStimulus(10);
        waitFireRise("press1", n);
        checkOutput("press1_latency", n, 7);
        scoreShots("press1_shots", shots_fired);
        waitFireFall("press1");
        checkOutput("press1_cooldown_ready", ready, 0);

        // Second press lands in cooldown.
        applyStimulus(10);
`ifdef FIRE_QUEUE_EN
        shotsModel++;
        expShots.push_back(shotsModel);
`endif
        waitTickEnd();
        checkOutput("cool_ready_after_1tick", ready, 0);
        waitTickEnd();
        checkOutput("cool_ready_after_2tick", ready, 1);
        step();
`ifdef FIRE_QUEUE_EN
        checkOutput("queued_fire", fire, 1);
        scoreShots("queued_shots", shots_fired);
        waitFireFall("queued");
        waitReadyHigh("queued_rearm", 80);
`else
        checkOutput("cool_press_fire", fire, 0);
        watchNoFire(20);
        checkOutput("cool_press_saw_fire", sawFire, 0);
        checkOutput("cool_press_shots", shots_fired, shotsModel);
`endif

        // Press while a bullet is on screen, then the bullet disappears.
        bullet_onscreen = 1'b1;
        waitTickEnd();
        applyStimulus(10);
        watchNoFire(20);
        checkOutput("bullet_saw_fire", sawFire, 0);
        checkOutput("bullet_ready", ready, 0);
        bullet_onscreen = 1'b0;
`ifdef FIRE_QUEUE_EN
        shotsModel++;
        expShots.push_back(shotsModel);
        step();
        checkOutput("bullet_fall_fire", fire, 1);
        scoreShots("bullet_fall_shots", shots_fired);
        waitFireFall("bullet");
        waitReadyHigh("bullet_rearm", 80);
`else
        step();
        checkOutput("bullet_fall_fire", fire, 0);
        watchNoFire(20);
        checkOutput("bullet_fall_saw_fire", sawFire, 0);
        checkOutput("bullet_fall_shots", shots_fired, shotsModel);
`endif

        // game_active dropped while firing.
        waitTickEnd();
        shotsModel++;
        expShots.push_back(shotsModel);
        applyStimulus(10);
        waitFireRise("ga", n);
        scoreShots("ga_shots_at_fire", shots_fired);
        game_active = 1'b0;
        step();
        checkOutput("ga_fire", fire, 0);
        checkOutput("ga_ready", ready, 0);
        checkOutput("ga_shots_held", shots_fired, shotsModel);
        game_active = 1'b1;
        step();
        checkOutput("ga_rearm_ready", ready, 1);
        repeat (10) step();

        // Reset in the middle of cooldown.
        waitTickEnd();
        shotsModel++;
        expShots.push_back(shotsModel);
        applyStimulus(10);
        waitFireRise("rst", n);
        scoreShots("rst_shots_at_fire", shots_fired);
        waitFireFall("rst");
        checkOutput("rst_in_cooldown", ready, 0);
        reset       = 1'b1;
        game_active = 1'b0;
        step();
        checkOutput("rst_fire", fire, 0);
        checkOutput("rst_shots", shots_fired, 0);
        checkOutput("rst_ready", ready, 0);
        reset       = 1'b0;
        game_active = 1'b1;
        shotsModel  = 0;
        expShots.delete();
        repeat (8) step();
        checkOutput("rst_rearm_ready", ready, 1);

        // Zero-cooldown instance: 256 shots, counter must stop at 255.
        for (int s = 0; s < 256; s++) begin
            if (shots0Model < 255) shots0Model++;
            expShots.push_back(shots0Model);
            btn0      = 1'b1;
            holdLeft0 = 8;
            n = 0;
            while (fire0 !== 1'b1 && n < 60) begin
                step();
                n++;
            end
            checkOutput("sat_rise_timeout", n >= 60, 0);
            scoreShots("sat_shots", shots0);
            n = 0;
            while (fire0 !== 1'b0 && n < 60) begin
                step();
                n++;
            end
            checkOutput("sat_fall_timeout", n >= 60, 0);
            repeat (8) step();
        end
        checkOutput("sat_final_shots", shots0, 255);
        checkOutput("sat_final_ready", ready0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
